// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared widths and record types for the register-file write-back front end.
// Every rtl/ file and the testbench import this package.
package regfile_writeback_arbiter_pkg;

   localparam int XLEN         = 32;
   localparam int AW           = 5;
   localparam int NUM_REGS     = 32;
   localparam int LQ_DEPTH_DEF = 4;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
      logic            stale;
   } wb_entry_t;

   typedef struct packed {
      logic            hit;
      logic [XLEN-1:0] data;
   } fwd_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of producer handshakes, register-file write port and forwarding lookups.
// The modports give each side its direction: master is the pipeline, slave is the arbiter.
interface regfile_writeback_arbiter_if #(
   parameter int LQ_DEPTH = regfile_writeback_arbiter_pkg::LQ_DEPTH_DEF
);
   import regfile_writeback_arbiter_pkg::*;

   localparam int CW = $clog2(LQ_DEPTH) + 1;

   // valid/ready: a transfer happens on a rising edge with valid && ready; the producer
   // holds its payload stable while valid && !ready; ready comes from registered state only.
   logic            alu_valid;
   logic            alu_ready;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_valid;
   logic            ld_ready;
   logic [AW-1:0]   ld_rd;
   logic [XLEN-1:0] ld_data;

   logic            rf_we;
   logic [AW-1:0]   rf_wr_addr;
   logic [XLEN-1:0] rf_wr_data;

   logic [AW-1:0]   fwd_addr1;
   logic            fwd_hit1;
   logic [XLEN-1:0] fwd_data1;
   logic [AW-1:0]   fwd_addr2;
   logic            fwd_hit2;
   logic [XLEN-1:0] fwd_data2;

   logic [CW-1:0]   lq_count;

   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_addr1, fwd_addr2,
      input  alu_ready, ld_ready, rf_we, rf_wr_addr, rf_wr_data,
             fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, lq_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_addr1, fwd_addr2,
      output alu_ready, ld_ready, rf_we, rf_wr_addr, rf_wr_data,
             fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, lq_count
   );

endinterface

// File: rtl/regfile_writeback_arbiter_wb_load_queue.sv
// In-order circular buffer of pending loads with an address-match stale-set port.
// Entries are also presented oldest-first so the forwarding search can scan them.
module wb_load_queue
   import regfile_writeback_arbiter_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_enq,
   input  wb_entry_t                   i_enq_entry,
   input  logic                        i_deq,
   input  logic                        i_kill_en,
   input  logic [AW-1:0]               i_kill_rd,
   output logic [CW-1:0]               o_count,
   output logic                        o_full,
   output wb_entry_t [DEPTH-1:0]       o_age_entry,
   output logic [DEPTH-1:0]            o_age_live
);

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_mem[i].rd == i_kill_rd) r_mem[i].stale <= 1'b1;
            end
         end
         // The enqueue write comes last so a freshly written tail slot is never killed.
         if (i_enq) begin
            r_mem[r_tail] <= i_enq_entry;
            r_tail        <= r_tail + 1'b1;
         end
         if (i_deq) r_head <= r_head + 1'b1;
         case ({i_enq, i_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));

   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign o_age_entry[k] = r_mem[r_head + PW'(k)];
      assign o_age_live[k]  = (CW'(k) < r_count);
   end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU results and queued load returns into the single register-file write port,
// with x0 suppression, write-after-write kill and a two-port forwarding lookup.
module regfile_writeback_arbiter
   import regfile_writeback_arbiter_pkg::*;
#(
   parameter  int LQ_DEPTH = regfile_writeback_arbiter_pkg::LQ_DEPTH_DEF,
   localparam int CW       = $clog2(LQ_DEPTH) + 1
) (
   input logic                         clk,
   input logic                         rst,
   regfile_writeback_arbiter_if.slave  wb
);

   logic                         w_full;
   logic                         w_alu_xfer;
   logic                         w_ld_xfer;
   logic                         w_enq;
   logic                         w_deq;
   logic                         w_kill_en;
   wb_entry_t                    w_enq_entry;
   logic [CW-1:0]                w_count;
   wb_entry_t [LQ_DEPTH-1:0]     w_age_entry;
   logic [LQ_DEPTH-1:0]          w_age_live;
   fwd_t                         w_fwd1;
   fwd_t                         w_fwd2;

   logic                         r_we;
   logic [AW-1:0]                r_addr;
   logic [XLEN-1:0]              r_data;

   assign wb.alu_ready = ~w_full;
   assign wb.ld_ready  = ~w_full;

   assign w_alu_xfer = wb.alu_valid & ~w_full;
   assign w_ld_xfer  = wb.ld_valid & ~w_full;
   assign w_enq      = w_ld_xfer && (wb.ld_rd != '0);
   // The ALU owns the issue slot whenever it transfers; the queue drains otherwise.
   assign w_deq      = !w_alu_xfer && (w_count != '0);
   assign w_kill_en  = w_alu_xfer && (wb.alu_rd != '0);

   // A same-cycle load to the ALU's rd is the older write, so it enters already dead.
   assign w_enq_entry = '{rd:    wb.ld_rd,
                          data:  wb.ld_data,
                          stale: w_alu_xfer && (wb.ld_rd == wb.alu_rd)};

   wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk         (clk),
      .rst         (rst),
      .i_enq       (w_enq),
      .i_enq_entry (w_enq_entry),
      .i_deq       (w_deq),
      .i_kill_en   (w_kill_en),
      .i_kill_rd   (wb.alu_rd),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_age_entry (w_age_entry),
      .o_age_live  (w_age_live)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (w_alu_xfer) begin
         r_we   <= (wb.alu_rd != '0);
         r_addr <= wb.alu_rd;
         r_data <= wb.alu_data;
      end else if (w_deq) begin
         r_we   <= (w_age_entry[0].rd != '0) && !w_age_entry[0].stale;
         r_addr <= w_age_entry[0].rd;
         r_data <= w_age_entry[0].data;
      end else begin
         r_we   <= 1'b0;
      end
   end

   assign wb.rf_we      = r_we;
   assign wb.rf_wr_addr = r_addr;
   assign wb.rf_wr_data = r_data;
   assign wb.lq_count   = w_count;

   // Later (younger) queue matches override the output register and older entries.
   function automatic fwd_t fwd_lookup(input logic [AW-1:0]          addr,
                                       input wb_entry_t [LQ_DEPTH-1:0] entries,
                                       input logic [LQ_DEPTH-1:0]    live,
                                       input logic                   out_we,
                                       input logic [AW-1:0]          out_addr,
                                       input logic [XLEN-1:0]        out_data);
      fwd_t res;
      res = '0;
      if (addr != '0) begin
         if (out_we && (out_addr == addr)) begin
            res.hit  = 1'b1;
            res.data = out_data;
         end
         for (int k = 0; k < LQ_DEPTH; k++) begin
            if (live[k] && !entries[k].stale && (entries[k].rd == addr)) begin
               res.hit  = 1'b1;
               res.data = entries[k].data;
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      w_fwd1 = fwd_lookup(wb.fwd_addr1, w_age_entry, w_age_live, r_we, r_addr, r_data);
      w_fwd2 = fwd_lookup(wb.fwd_addr2, w_age_entry, w_age_live, r_we, r_addr, r_data);
   end

   assign wb.fwd_hit1  = w_fwd1.hit;
   assign wb.fwd_data1 = w_fwd1.data;
   assign wb.fwd_hit2  = w_fwd2.hit;
   assign wb.fwd_data2 = w_fwd2.data;

endmodule
